// File: rtl/vmem_arbiter_pkg.sv
// Shared types and constants for the VRAM/OAM access arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vmem_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VID_RD,
        S_CPU_RD,
        S_CPU_WR,
        S_CPU_LOCK,
        S_ACK
    } vmem_state_t;

    localparam logic [1:0] MODE_HBLANK = 2'b00;
    localparam logic [1:0] MODE_VBLANK = 2'b01;
    localparam logic [1:0] MODE_OAM    = 2'b10;
    localparam logic [1:0] MODE_XFER   = 2'b11;

    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] VRAM_TOP  = 16'h9FFF;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam logic [15:0] OAM_TOP   = 16'hFE9F;

    localparam logic [7:0] LOCKED_RDATA = 8'hFF;

endpackage

// File: rtl/vmem_arbiter_addr_decode.sv
// CPU address decode: classifies a bus address as VRAM, OAM or unmapped and forms the array address.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cpu_addr in; is_vram / is_oam / is_invalid / arr_addr out.
module vmem_addr_decode
    import vmem_arbiter_pkg::*;
(
    input  logic [15:0] cpu_addr,
    output logic        is_vram,
    output logic        is_oam,
    output logic        is_invalid,
    output logic [12:0] arr_addr
);

    assign is_vram    = (cpu_addr >= VRAM_BASE) && (cpu_addr <= VRAM_TOP);
    // OAM indices 0xA0-0xFF fall outside OAM_TOP and therefore decode as unmapped.
    assign is_oam     = (cpu_addr >= OAM_BASE) && (cpu_addr <= OAM_TOP);
    assign is_invalid = !is_vram && !is_oam;
    assign arr_addr   = is_oam ? {5'b0, cpu_addr[7:0]} : cpu_addr[12:0];

endmodule

// File: rtl/vmem_arbiter.sv
// Arbitrates the single-port VRAM/OAM arrays between CPU bus and display fetch, with display-mode locking.
// Latency: grant, strobe, ack cycles (ack in 3rd cycle of a request); one access per 3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; CPU forced in after CPU_MAX_WAIT losses in modes 00/01.
// Ports: clk_cpu/rst_n; mode; cpu_* and vid_* request/ack/rdata; mem_* array bus and one-hot strobes.
module vmem_arbiter
    import vmem_arbiter_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 8,
    parameter int LOCK_ENABLE  = 1
) (
    input  logic        clk_cpu,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        vid_req,
    input  logic        vid_oam,
    input  logic [12:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        vram_oe,
    output logic        vram_we,
    output logic        oam_oe,
    output logic        oam_we
);

    localparam int WW = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);

    vmem_state_t   state_q, state_d;
    logic [WW-1:0] wait_cnt_q;
    logic [12:0]   mem_addr_q;
    logic [7:0]    mem_wdata_q;
    logic          tgt_oam_q;
    logic          owner_cpu_q;
    logic          lock_q;
    logic          we_q;
    logic [7:0]    cpu_rdata_q;
    logic [7:0]    vid_rdata_q;

    logic          is_vram, is_oam, is_invalid;
    logic [12:0]   cpu_arr_addr;
    logic          locked;
    logic          cpu_wins, vid_wins;
    logic [7:0]    ack_rdata;

    vmem_addr_decode u_decode (
        .cpu_addr   (cpu_addr),
        .is_vram    (is_vram),
        .is_oam     (is_oam),
        .is_invalid (is_invalid),
        .arr_addr   (cpu_arr_addr)
    );

    // Unmapped addresses are locked even in debug builds: there is no array to touch.
    assign locked = ((LOCK_ENABLE != 0) &&
                     ((is_vram && (mode == MODE_XFER)) || (is_oam && mode[1]))) ||
                    is_invalid;

    // Video has priority; the CPU is forced through only in blanking once it has lost enough times.
    assign cpu_wins = cpu_req && (!vid_req || (!mode[1] && (wait_cnt_q == WAIT_MAX)));
    assign vid_wins = vid_req && !cpu_wins;

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_wins) begin
                    if (locked)      state_d = S_CPU_LOCK;
                    else if (cpu_we) state_d = S_CPU_WR;
                    else             state_d = S_CPU_RD;
                end else if (vid_wins) begin
                    state_d = S_VID_RD;
                end
            end
            S_VID_RD, S_CPU_RD, S_CPU_WR, S_CPU_LOCK: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant-time capture of the access descriptor; lock is frozen here so a mode change cannot abort.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tgt_oam_q   <= 1'b0;
            owner_cpu_q <= 1'b0;
            lock_q      <= 1'b0;
            we_q        <= 1'b0;
            cpu_rdata_q <= 8'h00;
            vid_rdata_q <= 8'h00;
        end else begin
            if (state_q == S_IDLE) begin
                if (cpu_wins) begin
                    mem_addr_q  <= cpu_arr_addr;
                    mem_wdata_q <= cpu_wdata;
                    tgt_oam_q   <= is_oam;
                    owner_cpu_q <= 1'b1;
                    lock_q      <= locked;
                    we_q        <= cpu_we;
                    wait_cnt_q  <= '0;
                end else if (vid_wins) begin
                    mem_addr_q  <= vid_addr;
                    tgt_oam_q   <= vid_oam;
                    owner_cpu_q <= 1'b0;
                    lock_q      <= 1'b0;
                    we_q        <= 1'b0;
                    if (cpu_req && (wait_cnt_q != WAIT_MAX)) begin
                        wait_cnt_q <= wait_cnt_q + WW'(1);
                    end
                end
            end
            if (cpu_ack && !we_q) cpu_rdata_q <= ack_rdata;
            if (vid_ack)          vid_rdata_q <= mem_rdata;
        end
    end

    // Strobes decode straight from the state register so they fall the instant rst_n asserts.
    assign vram_oe = ((state_q == S_VID_RD) || (state_q == S_CPU_RD)) && !tgt_oam_q;
    assign oam_oe  = ((state_q == S_VID_RD) || (state_q == S_CPU_RD)) &&  tgt_oam_q;
    assign vram_we = (state_q == S_CPU_WR) && !tgt_oam_q;
    assign oam_we  = (state_q == S_CPU_WR) &&  tgt_oam_q;

    assign cpu_ack = (state_q == S_ACK) &&  owner_cpu_q;
    assign vid_ack = (state_q == S_ACK) && !owner_cpu_q;

    // Array data lands during S_ACK; bypass it so rdata is valid in the same cycle as the ack.
    assign ack_rdata = lock_q ? LOCKED_RDATA : mem_rdata;
    assign cpu_rdata = (cpu_ack && !we_q) ? ack_rdata : cpu_rdata_q;
    assign vid_rdata = vid_ack ? mem_rdata : vid_rdata_q;

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
